// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA timing constant sets and total-length helper
//
// Contents:
//   axis_timing_t  : active/front-porch/sync/back-porch lengths for one axis
//   timing_set_t   : horizontal and vertical axis timings for one video mode
//   VGA_640X480_60 : standard 640x480 at 60 Hz (25.175 MHz pixel clock)
//   VGA_800X600_60 : standard 800x600 at 60 Hz (40 MHz pixel clock)
//   VGA_SIM_SMALL  : 12x10 raster, small enough to step through frames quickly
//   timing_total() : sum of the four segment lengths of an axis
package vga_timing_pkg;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } axis_timing_t;

    typedef struct packed {
        axis_timing_t h;
        axis_timing_t v;
    } timing_set_t;

    localparam timing_set_t VGA_640X480_60 = '{
        h: '{active: 640, fp: 16, sync: 96,  bp: 48},
        v: '{active: 480, fp: 10, sync: 2,   bp: 33}
    };

    localparam timing_set_t VGA_800X600_60 = '{
        h: '{active: 800, fp: 40, sync: 128, bp: 88},
        v: '{active: 600, fp: 1,  sync: 4,   bp: 23}
    };

    localparam timing_set_t VGA_SIM_SMALL = '{
        h: '{active: 8,   fp: 1,  sync: 2,   bp: 1},
        v: '{active: 4,   fp: 2,  sync: 1,   bp: 3}
    };

    function automatic int timing_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_pixel_tick_gen.sv
// rtl/vga_pixel_tick_gen.sv - system-clock prescaler producing the pixel strobe
//
// Ports:
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset, clears the prescaler
//   en_i    : prescaler advances only while high; held value survives a pause
//   tick_o  : one-clock strobe on the last system clock of each pixel period
module vga_pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic tick_o
);

    // A divide-by-1 still needs a 1-bit register; it simply stays at zero.
    localparam int             PW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]  P_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          at_last;

    assign at_last = (presc_q == P_LAST);

    // Combinational from the register so the strobe lines up with the counter
    // state it advances, and drops the instant Enable is removed.
    assign tick_o  = en_i & at_last;

    always_comb begin
        presc_d = presc_q;
        if (en_i) begin
            presc_d = at_last ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator
//
// Ports:
//   clk_i         : system clock
//   rst_ni        : asynchronous active-low reset, returns raster to (0,0)
//   en_i          : run when 1; freeze all timing when 0
//   pixel_tick_o  : one-clock strobe per pixel period
//   xpos_o        : horizontal position, 0..H_TOTAL-1
//   ypos_o        : vertical position, 0..V_TOTAL-1
//   hsync_o       : horizontal sync, registered, asserted level HS_POL
//   vsync_o       : vertical sync, registered, asserted level VS_POL
//   video_on_o    : registered visible-area flag
//   line_end_o    : strobe on the tick where xpos wraps
//   frame_end_o   : strobe on the tick where xpos and ypos both wrap
//   frame_count_o : 16-bit wrapping frame counter, only present when
//                   VGA_TIMING_FRAME_CNT_EN is defined
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CW       = 11,
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = VGA_640X480_60.h.active,
    parameter int H_FP     = VGA_640X480_60.h.fp,
    parameter int H_SYNC   = VGA_640X480_60.h.sync,
    parameter int H_BP     = VGA_640X480_60.h.bp,
    parameter int V_ACTIVE = VGA_640X480_60.v.active,
    parameter int V_FP     = VGA_640X480_60.v.fp,
    parameter int V_SYNC   = VGA_640X480_60.v.sync,
    parameter int V_BP     = VGA_640X480_60.v.bp,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    output logic          pixel_tick_o,
    output logic [CW-1:0] xpos_o,
    output logic [CW-1:0] ypos_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          video_on_o,
    output logic          line_end_o,
    output logic          frame_end_o
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_count_o
`endif
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (H_TOTAL >= (1 << CW)) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
    end
    if (V_TOTAL >= (1 << CW)) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
    end

    localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] X_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] Y_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic          HS_ON    = (HS_POL != 0);
    localparam logic          VS_ON    = (VS_POL != 0);

    logic          tick;
    logic          x_last;
    logic          y_last;
    logic [CW-1:0] x_q;
    logic [CW-1:0] x_d;
    logic [CW-1:0] y_q;
    logic [CW-1:0] y_d;
    logic          hs_q;
    logic          hs_d;
    logic          vs_q;
    logic          vs_d;
    logic          von_q;
    logic          von_d;

    vga_pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (en_i),
        .tick_o (tick)
    );

    assign x_last      = (x_q == X_LAST);
    assign y_last      = (y_q == Y_LAST);
    assign line_end_o  = tick & x_last;
    assign frame_end_o = line_end_o & y_last;

    // Sync and blanking decode the next-state position so that, once
    // registered, they change on the same edge as xpos/ypos.  When Enable
    // is low the next state equals the held state, so the syncs hold too.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (tick) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
        hs_d  = ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) ? HS_ON : ~HS_ON;
        vs_d  = ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) ? VS_ON : ~VS_ON;
        // Blank while paused so renderers never draw a frozen pixel.
        von_d = en_i & (x_d < X_ACT) & (y_d < Y_ACT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q   <= '0;
            y_q   <= '0;
            hs_q  <= ~HS_ON;
            vs_q  <= ~VS_ON;
            von_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            von_q <= von_d;
        end
    end

    assign pixel_tick_o = tick;
    assign xpos_o       = x_q;
    assign ypos_o       = y_q;
    assign hsync_o      = hs_q;
    assign vsync_o      = vs_q;
    assign video_on_o   = von_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_cnt_q <= '0;
        end else if (frame_end_o) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_count_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a_n, en_a, tick_a, hs_a, vs_a, von_a, le_a, fe_a;
    logic [3:0] x_a, y_a;
    logic       rst_b_n, en_b, tick_b, hs_b, vs_b, von_b, le_b, fe_b;
    logic [3:0] x_b, y_b;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] fc_a, fc_b;
`endif

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Small raster, CLK_DIV=2, active-low syncs.
    vga_timing_gen #(
        .CW(4), .CLK_DIV(2),
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(2), .V_SYNC(1), .V_BP(3),
        .HS_POL(0), .VS_POL(0)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_a_n), .en_i(en_a),
        .pixel_tick_o(tick_a), .xpos_o(x_a), .ypos_o(y_a),
        .hsync_o(hs_a), .vsync_o(vs_a), .video_on_o(von_a),
        .line_end_o(le_a), .frame_end_o(fe_a)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_count_o(fc_a)
`endif
    );

    // Same raster, one pixel per clock, active-high hsync.
    vga_timing_gen #(
        .CW(4), .CLK_DIV(1),
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(2), .V_SYNC(1), .V_BP(3),
        .HS_POL(1), .VS_POL(0)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_b_n), .en_i(en_b),
        .pixel_tick_o(tick_b), .xpos_o(x_b), .ypos_o(y_b),
        .hsync_o(hs_b), .vsync_o(vs_b), .video_on_o(von_b),
        .line_end_o(le_b), .frame_end_o(fe_b)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_count_o(fc_b)
`endif
    );

    initial begin
        int ph, dis, xe, ye, k;
        int le_cnt, fe_cnt, vs_low, hs_low;
        bit en_last, dropped, tk;

        rst_a_n = 1'b0; en_a = 1'b1;
        rst_b_n = 1'b0; en_b = 1'b1;
        repeat (3) @(negedge clk);

        check_val("rst_x",     x_a,    0);
        check_val("rst_y",     y_a,    0);
        check_val("rst_hsync", hs_a,   1);
        check_val("rst_vsync", vs_a,   1);
        check_val("rst_von",   von_a,  0);
        check_val("rst_tick",  tick_a, 0);
        check_val("rst_le",    le_a,   0);

        rst_a_n = 1'b1;
        ph = 0; dis = 0; en_last = 1'b0; dropped = 1'b0;
        le_cnt = 0; fe_cnt = 0; vs_low = 0; hs_low = 0;

        // ph counts enabled edges since release; every output follows from it.
        while (ph < 428) begin
            @(posedge clk);
            if (en_a) ph++;
            en_last = en_a;
            @(negedge clk);
            xe = (ph / 2) % 12;
            ye = (ph / 24) % 10;
            tk = en_a && (ph % 2 == 1);
            check_val("a_x",     x_a,    xe);
            check_val("a_y",     y_a,    ye);
            check_val("a_tick",  tick_a, int'(tk));
            check_val("a_hsync", hs_a,   int'(!(xe == 9 || xe == 10)));
            check_val("a_vsync", vs_a,   int'(ye != 6));
            check_val("a_von",   von_a,  int'(en_last && xe < 8 && ye < 4));
            check_val("a_le",    le_a,   int'(tk && xe == 11));
            check_val("a_fe",    fe_a,   int'(tk && xe == 11 && ye == 9));
            if (le_a) le_cnt++;
            if (fe_a) fe_cnt++;
            if (ph < 240 && !vs_a) vs_low++;
            if (ph < 24 && !hs_a) hs_low++;
            if (dis > 0) begin
                dis--;
                if (dis == 0) en_a = 1'b1;
            end else if (!dropped && ph == 58) begin
                en_a = 1'b0;
                dis = 7;
                dropped = 1'b1;
            end
        end

        check_val("a_line_ends",   le_cnt, 17);
        check_val("a_frame_ends",  fe_cnt, 1);
        check_val("a_vsync_low",   vs_low, 24);
        check_val("a_hsync_low",   hs_low, 4);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check_val("a_frame_count", fc_a,   1);
`endif

        // Now at (10,7) inside hsync: reset must clear without a clock edge.
        rst_a_n = 1'b0;
        #1;
        check_val("mid_rst_x",     x_a,   0);
        check_val("mid_rst_y",     y_a,   0);
        check_val("mid_rst_hsync", hs_a,  1);
        check_val("mid_rst_vsync", vs_a,  1);
        check_val("mid_rst_von",   von_a, 0);

        @(negedge clk);
        rst_b_n = 1'b1;
        k = 0;
        repeat (360) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            xe = k % 12;
            ye = (k / 12) % 10;
            check_val("b_tick",  tick_b, 1);
            check_val("b_x",     x_b,    xe);
            check_val("b_y",     y_b,    ye);
            check_val("b_hsync", hs_b,   int'(xe == 9 || xe == 10));
            check_val("b_vsync", vs_b,   int'(ye != 6));
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        check_val("b_frame_count", fc_b, 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator. Successor to the fixed 10-bit CRT controller: it adds per-axis porch/sync parameters, sync polarity, a run/pause enable, a registered blanking flag and frame/line strobes. It sits between the system clock domain and the pixel/sprite renderers (Pong paddles, ball), and supplies xpos/ypos plus sync outputs to the VGA connector.

Parameters:
CW, 11, width of the position counters and xpos/ypos
CLK_DIV, 4, system clocks per pixel (≥1); 1 gives a pixel_tick every cycle
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch in pixels
H_SYNC, 96, hsync width in pixels
H_BP, 48, horizontal back porch in pixels
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch in lines
V_SYNC, 2, vsync width in lines
V_BP, 33, vertical back porch in lines
HS_POL, 0, asserted level of hsync
VS_POL, 0, asserted level of vsync

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-low reset
Enable  in  1  run when 1; freeze all timing when 0
pixel_tick  out  1  one-Clock strobe per pixel period
xpos  out  CW  horizontal counter, 0..H_TOTAL-1
ypos  out  CW  vertical counter, 0..V_TOTAL-1
hsync  out  1  horizontal sync, registered
vsync  out  1  vertical sync, registered
video_on  out  1  1 iff xpos<H_ACTIVE and ypos<V_ACTIVE, registered
line_end  out  1  strobe on the tick where xpos wraps
frame_end  out  1  strobe on the tick where both xpos and ypos wrap

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Both must be < 2^CW. An elaboration-time check fails on violation or on CLK_DIV=0.
- Reset low (asynchronous): prescaler=0, xpos=0, ypos=0, hsync=~HS_POL, vsync=~VS_POL, video_on=0.
- Prescaler counts 0..CLK_DIV-1 while Enable=1. pixel_tick = Enable & (prescaler==CLK_DIV-1), combinational from the prescaler register.
- On pixel_tick: xpos increments; if xpos==H_TOTAL-1 it wraps to 0 and ypos increments. If ypos==V_TOTAL-1 at that point, ypos wraps to 0.
- line_end = pixel_tick & (xpos==H_TOTAL-1). frame_end = line_end & (ypos==V_TOTAL-1). Both are combinational and one Clock wide.
- hsync, vsync and video_on are registered and decoded from the next-state counter values, so they align with xpos/ypos in the same cycle with no lag and no glitch.
- hsync is asserted (HS_POL) for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. vsync is asserted (VS_POL) for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], over whole lines.
- Enable=0: prescaler, xpos and ypos hold; hsync and vsync hold; video_on is forced to 0 on the next edge; pixel_tick, line_end and frame_end are 0.
- Enable re-asserted: counting resumes from the held prescaler value. video_on shows the decode of the held position on the next edge.
- Reset mid-frame returns to (0,0) immediately. After release the first edge with Enable=1 sets video_on=1.
- Latency from the reset-release edge to the first pixel_tick is CLK_DIV Clock cycles.

Optional Feature:
Macro VGA_TIMING_FRAME_CNT_EN.
- Defined: adds output frame_count (16 bits), reset to 0, incremented on frame_end, wrapping from 0xFFFF to 0. Intended for ball-speed and animation pacing.
- Undefined: the port and its register do not exist.

Decomposition:
- Package vga_timing_pkg holds named timing constant sets (640x480@60, 800x600@60, and the small simulation set below) and a function computing the total from four segment lengths.
- One sub-module, vga_pixel_tick_gen, contains the prescaler and Enable gating. It is instantiated once.

Test Plan (sim params: CLK_DIV=2, H 8/1/2/1 giving H_TOTAL=12, V 4/2/1/3 giving V_TOTAL=10, CW=4, polarity 0):
- Reset held low, then released with Enable=1: all outputs hold reset values during reset; first pixel_tick is 2 Clocks after release; video_on=1 on the first edge.
- Free-run: hsync=0 exactly for xpos 9..10 (4 Clocks per line); video_on=0 for xpos 8..11; line_end every 24 Clocks.
- Frame: vsync=0 only while ypos=6 (24 Clocks); frame_end once every 240 Clocks, coincident with line_end at (11,9).
- Enable dropped at (5,2) for 7 Clocks: counters and syncs hold, video_on=0, no strobes. Resume continues from x=5 with the original phase.
- Reset asserted at (10,7) mid-sync: within the same cycle, hsync=1, vsync=1, xpos=0, ypos=0.
- CLK_DIV=1 with HS_POL=1: pixel_tick is constant 1 while Enable=1; hsync=1 for xpos 9..10. With VGA_TIMING_FRAME_CNT_EN defined, frame_count reaches 3 after 360 Clocks.
